// File: rtl/if_inst_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : if_inst_queue_pkg
//  Purpose  : Shared fetch-side definitions for the instruction queue:
//             default depth, exception-field width, the packed fetch-exception
//             type and the queue entry type {pc, instr, exc}.
//  Revision : 1.0 - initial release
// ============================================================================
package if_inst_queue_pkg;

  localparam int IFQ_DEPTH = 4;
  localparam int IFQ_EXC_W = 8;

  // Fetch exception bits produced alongside each ICache return.
  typedef struct packed {
    logic       adel;          // misaligned / illegal fetch address
    logic       tlbl_refill;   // TLB refill on instruction fetch
    logic       tlbl_invalid;  // TLB entry invalid on instruction fetch
    logic       bus_err;       // instruction bus error
    logic [3:0] rsvd;          // room for further fetch faults
  } fetch_exc_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    fetch_exc_t  exc;
  } if_entry_t;

endpackage : if_inst_queue_pkg
`default_nettype wire

// File: rtl/if_inst_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : if_inst_queue_if
//  Purpose  : Bundle of every signal between fetch/ICache, the instruction
//             queue and decode.
//  Ports    : flush                            - redirect/exception flush
//             enq_valid/pc/instr/exc/ready     - ICache side handshake
//             deq_valid/pc/instr/exc/ready     - decode side handshake
//             count                            - queue occupancy
//  Modports : slave  - the queue itself
//             master - the surrounding pipeline (fetch + decode)
//  Revision : 1.0 - initial release
// ============================================================================
interface if_inst_queue_if
  import if_inst_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int EXC_W = IFQ_EXC_W
) ();

  logic                     flush;
  logic                     enq_valid;
  logic [31:0]              enq_pc;
  logic [31:0]              enq_instr;
  logic [EXC_W-1:0]         enq_exc;
  logic                     enq_ready;
  logic                     deq_valid;
  logic [31:0]              deq_pc;
  logic [31:0]              deq_instr;
  logic [EXC_W-1:0]         deq_exc;
  logic                     deq_ready;
  logic [$clog2(DEPTH):0]   count;

  modport slave (
    input  flush, enq_valid, enq_pc, enq_instr, enq_exc, deq_ready,
    output enq_ready, deq_valid, deq_pc, deq_instr, deq_exc, count
  );

  modport master (
    output flush, enq_valid, enq_pc, enq_instr, enq_exc, deq_ready,
    input  enq_ready, deq_valid, deq_pc, deq_instr, deq_exc, count
  );

endinterface : if_inst_queue_if
`default_nettype wire

// File: rtl/if_inst_queue.sv
`default_nettype none
// ============================================================================
//  Module   : if_inst_queue
//  Purpose  : DEPTH-entry in-order instruction queue between the ICache
//             return path and the decode stage. Absorbs in-flight fetches
//             while decode stalls; emptied by a flush (redirect/exception).
//  Ports    : clk    - core clock, rising edge
//             resetn - asynchronous active-low reset
//             q      - if_inst_queue_if.slave (enq/deq handshakes, flush,
//                      occupancy count)
//  Revision : 1.0 - initial release
// ============================================================================
module if_inst_queue
  import if_inst_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int EXC_W = IFQ_EXC_W
) (
  input  logic           clk,
  input  logic           resetn,
  if_inst_queue_if.slave q
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Same layout as if_entry_t, but sized by this instance's EXC_W.
  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic [EXC_W-1:0] exc;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;

  logic   w_full;
  logic   w_empty;
  logic   w_enq_fire;
  logic   w_deq_fire;
  entry_t w_head;
  entry_t w_new;

  // Status is derived from registered occupancy only, so enq_ready has no
  // combinational path from deq_ready.
  assign w_full  = (r_cnt == FULL_CNT);
  assign w_empty = (r_cnt == '0);

  // Flush wins over both handshakes in the same cycle.
  assign w_enq_fire = q.enq_valid & ~w_full  & ~q.flush;
  assign w_deq_fire = q.deq_ready & ~w_empty & ~q.flush;

  assign w_new.pc    = q.enq_pc;
  assign w_new.instr = q.enq_instr;
  assign w_new.exc   = q.enq_exc;

  // Stale storage is never exposed: outputs read as zero while empty.
  assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

  assign q.enq_ready = ~w_full;
  assign q.deq_valid = ~w_empty;
  assign q.deq_pc    = w_head.pc;
  assign q.deq_instr = w_head.instr;
  assign q.deq_exc   = w_head.exc;
  assign q.count     = r_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (q.flush) begin
      // Entry contents are left as-is; the zeroed count masks them.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_enq_fire) begin
        r_mem[r_wr_ptr] <= w_new;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_deq_fire) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_enq_fire, w_deq_fire})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  a_cnt_bound: assert property (@(posedge clk) disable iff (!resetn)
    r_cnt <= FULL_CNT);
  a_no_deq_empty: assert property (@(posedge clk) disable iff (!resetn)
    w_deq_fire |-> !w_empty);
  a_no_wr_full: assert property (@(posedge clk) disable iff (!resetn)
    w_enq_fire |-> !w_full);

endmodule : if_inst_queue
`default_nettype wire
